// File: rtl/rx_tlp_trigger_gen_pkg.sv
// Shared widths, defaults and state encodings for the RX TLP trigger generator.
package rx_tlp_trigger_gen_pkg;

   localparam int unsigned BF                   = 9;
   localparam int unsigned PTR_W                = BF + 1;
   localparam int unsigned PAGE_W               = 19;
   localparam int unsigned QW_W                 = 5;
   localparam int unsigned DEF_MAX_TLP_QWORDS   = 16;
   localparam int unsigned DEF_HUGE_PAGE_QWORDS = 262128;
   localparam int unsigned DEF_TIMEOUT_CYCLES   = 1024;

   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [PAGE_W-1:0] page_cnt_t;
   typedef logic [QW_W-1:0]   qw_cnt_t;

   typedef enum logic [4:0] {
      IDLE        = 5'b00001,
      WAIT_ACK    = 5'b00010,
      WAIT_COMMIT = 5'b00100,
      WAIT_LAST   = 5'b01000,
      WAIT_CHG    = 5'b10000
   } trig_state_e;

endpackage

// File: rtl/rx_tlp_trigger_gen_if.sv
// Request/ack handshake between the trigger generator (master) and the TLP writer (slave).
interface rx_tlp_trigger_gen_if;
   import rx_tlp_trigger_gen_pkg::*;

   logic    trigger_tlp;
   logic    trigger_tlp_ack;
   logic    send_last_tlp;
   logic    change_huge_page;
   logic    change_huge_page_ack;
   qw_cnt_t qwords_to_send;

   modport master (
      output trigger_tlp, send_last_tlp, change_huge_page, qwords_to_send,
      input  trigger_tlp_ack, change_huge_page_ack
   );

   modport slave (
      input  trigger_tlp, send_last_tlp, change_huge_page, qwords_to_send,
      output trigger_tlp_ack, change_huge_page_ack
   );

endinterface

// File: rtl/rx_idle_timer.sv
// Saturating idle counter; expired_c is high once TIMEOUT_CYCLES-1 increments have accumulated.
module rx_idle_timer
   import rx_tlp_trigger_gen_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic trn_clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n)                count <= '0;
      else if (clr)                count <= '0;
      else if (en && !expired_c)   count <= count + CNT_W'(1);
   end

   assign expired_c = (count == LAST_CNT);

endmodule

// File: rtl/rx_tlp_trigger_gen.sv
// Decides when the huge-page TLP writer sends a full TLP, a short last TLP, or closes the page.
module rx_tlp_trigger_gen
   import rx_tlp_trigger_gen_pkg::*;
#(
   parameter int unsigned MAX_TLP_QWORDS   = DEF_MAX_TLP_QWORDS,
   parameter int unsigned HUGE_PAGE_QWORDS = DEF_HUGE_PAGE_QWORDS,
   parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
   input  logic                 trn_clk,
   input  logic                 reset_n,
   input  ptr_t                 commited_wr_address,
   input  ptr_t                 commited_rd_address,
   input  logic                 huge_page_available,
   rx_tlp_trigger_gen_if.master tlp
);

   localparam page_cnt_t MAX_P  = PAGE_W'(MAX_TLP_QWORDS);
   localparam page_cnt_t PAGE_P = PAGE_W'(HUGE_PAGE_QWORDS);

   trig_state_e state_q, state_d;
   logic        trig_q, trig_d;
   logic        last_q, last_d;
   logic        chg_q, chg_d;
   qw_cnt_t     qw_q, qw_d;
   page_cnt_t   page_qwords, page_d;
   ptr_t        last_rd, last_rd_d;
   logic        tmr_clr, tmr_en, tmr_expired_c;
   logic        ack_taken;

   ptr_t        avail, rd_delta;
   page_cnt_t   avail_p, remaining;
   logic        rd_moved;

   assign avail     = commited_wr_address - commited_rd_address;
   assign rd_delta  = commited_rd_address - last_rd;
   assign rd_moved  = (commited_rd_address != last_rd);
   assign avail_p   = PAGE_W'(avail);
   assign remaining = PAGE_P - page_qwords;

   rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
      .trn_clk   (trn_clk),
      .reset_n   (reset_n),
      .clr       (tmr_clr),
      .en        (tmr_en),
      .expired_c (tmr_expired_c)
   );

   // Next-state, next-output and commit tracking
   always_comb begin
      state_d   = state_q;
      trig_d    = trig_q;
      last_d    = last_q;
      chg_d     = chg_q;
      qw_d      = qw_q;
      page_d    = page_qwords;
      last_rd_d = last_rd;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      ack_taken = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!huge_page_available) begin
               tmr_clr = 1'b1;
            end else if (remaining == '0) begin
               chg_d   = 1'b1;
               state_d = WAIT_CHG;
            end else if (remaining >= MAX_P && avail_p >= MAX_P) begin
               trig_d  = 1'b1;
               qw_d    = QW_W'(MAX_TLP_QWORDS);
               state_d = WAIT_ACK;
            end else if (remaining < MAX_P && avail_p >= remaining) begin
               last_d  = 1'b1;
               qw_d    = QW_W'(remaining);
               state_d = WAIT_LAST;
            end else if (avail == '0) begin
               tmr_clr = 1'b1;
            end else if (tmr_expired_c) begin
               // Partial TLP has waited long enough: flush what is there
               last_d  = 1'b1;
               qw_d    = QW_W'(avail);
               state_d = WAIT_LAST;
            end else begin
               tmr_en  = 1'b1;
            end
         end
         WAIT_ACK: begin
            if (tlp.trigger_tlp_ack) begin
               trig_d    = 1'b0;
               ack_taken = 1'b1;
               state_d   = WAIT_COMMIT;
            end
         end
         WAIT_COMMIT: begin
            if (rd_moved) begin
               tmr_clr = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_LAST: begin
            if (rd_moved) begin
               last_d  = 1'b0;
               chg_d   = 1'b1;
               state_d = WAIT_CHG;
            end
         end
         WAIT_CHG: begin
            if (tlp.change_huge_page_ack) begin
               chg_d     = 1'b0;
               page_d    = '0;
               tmr_clr   = 1'b1;
               ack_taken = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            trig_d  = 1'b0;
            last_d  = 1'b0;
            chg_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      // A commit coinciding with an ack is picked up next cycle from last_rd
      if (rd_moved && !ack_taken) begin
         page_d    = page_qwords + PAGE_W'(rd_delta);
         last_rd_d = commited_rd_address;
      end
   end

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         trig_q      <= 1'b0;
         last_q      <= 1'b0;
         chg_q       <= 1'b0;
         qw_q        <= '0;
         page_qwords <= '0;
         last_rd     <= '0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_d;
         last_q      <= last_d;
         chg_q       <= chg_d;
         qw_q        <= qw_d;
         page_qwords <= page_d;
         last_rd     <= last_rd_d;
      end
   end

   assign tlp.trigger_tlp      = trig_q;
   assign tlp.send_last_tlp    = last_q;
   assign tlp.change_huge_page = chg_q;
   assign tlp.qwords_to_send   = qw_q;

endmodule

// File: tb/tb_rx_tlp_trigger_gen.sv
// Directed bench: default-page instance for full/wrap/timeout, small-page instance for boundary and reset.
module tb_rx_tlp_trigger_gen;
   import rx_tlp_trigger_gen_pkg::*;

   logic trn_clk = 1'b0;
   always #5 trn_clk = ~trn_clk;

   logic rst_a_n, rst_b_n;
   ptr_t wr_a, rd_a, wr_b, rd_b;
   logic hpa_a, hpa_b;

   rx_tlp_trigger_gen_if if_a ();
   rx_tlp_trigger_gen_if if_b ();

   rx_tlp_trigger_gen dut_a (
      .trn_clk             (trn_clk),
      .reset_n             (rst_a_n),
      .commited_wr_address (wr_a),
      .commited_rd_address (rd_a),
      .huge_page_available (hpa_a),
      .tlp                 (if_a)
   );

   rx_tlp_trigger_gen #(.HUGE_PAGE_QWORDS(40)) dut_b (
      .trn_clk             (trn_clk),
      .reset_n             (rst_b_n),
      .commited_wr_address (wr_b),
      .commited_rd_address (rd_b),
      .huge_page_available (hpa_b),
      .tlp                 (if_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic outs_a(input string tag, input logic t, input logic l, input logic c, input logic [4:0] q);
      check({tag, "_trig"}, 32'(if_a.trigger_tlp), 32'(t));
      check({tag, "_last"}, 32'(if_a.send_last_tlp), 32'(l));
      check({tag, "_chg"},  32'(if_a.change_huge_page), 32'(c));
      check({tag, "_qw"},   32'(if_a.qwords_to_send), 32'(q));
   endtask

   task automatic outs_b(input string tag, input logic t, input logic l, input logic c, input logic [4:0] q);
      check({tag, "_trig"}, 32'(if_b.trigger_tlp), 32'(t));
      check({tag, "_last"}, 32'(if_b.send_last_tlp), 32'(l));
      check({tag, "_chg"},  32'(if_b.change_huge_page), 32'(c));
      check({tag, "_qw"},   32'(if_b.qwords_to_send), 32'(q));
   endtask

   task automatic step_a(input int wr, input int rd, input logic hpa, input logic ta, input logic ca);
      wr_a = PTR_W'(wr); rd_a = PTR_W'(rd); hpa_a = hpa;
      if_a.trigger_tlp_ack = ta; if_a.change_huge_page_ack = ca;
      @(posedge trn_clk); #1;
   endtask

   task automatic step_b(input int wr, input int rd, input logic hpa, input logic ta, input logic ca);
      wr_b = PTR_W'(wr); rd_b = PTR_W'(rd); hpa_b = hpa;
      if_b.trigger_tlp_ack = ta; if_b.change_huge_page_ack = ca;
      @(posedge trn_clk); #1;
   endtask

   typedef struct {
      int         wr;
      int         rd;
      logic       hpa;
      logic       tack;
      logic       cack;
      logic       trig;
      logic       last;
      logic       chg;
      logic [4:0] qw;
      int         page;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      logic early;

      // Full TLP, commit gating, simultaneous ack+commit, pointer wrap, buffer full
      vecs[0]  = '{0,    0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0};
      vecs[1]  = '{32,   0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 0};
      vecs[2]  = '{32,   0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 0};
      vecs[3]  = '{32,   0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 0};
      vecs[4]  = '{32,   0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 0};
      vecs[5]  = '{32,   16,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 16};
      vecs[6]  = '{32,   16,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 16};
      vecs[7]  = '{32,   32,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 16};
      vecs[8]  = '{32,   32,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 32};
      vecs[9]  = '{32,   32,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 32};
      vecs[10] = '{1016, 1016, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1016};
      vecs[11] = '{8,    1016, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 1016};
      vecs[12] = '{8,    1016, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1016};
      vecs[13] = '{8,    8,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1032};
      vecs[14] = '{7,    8,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 1032};
      vecs[15] = '{7,    8,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1032};
      vecs[16] = '{7,    24,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1048};

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      wr_a = '0; rd_a = '0; hpa_a = 1'b0; wr_b = '0; rd_b = '0; hpa_b = 1'b0;
      if_a.trigger_tlp_ack = 1'b0; if_a.change_huge_page_ack = 1'b0;
      if_b.trigger_tlp_ack = 1'b0; if_b.change_huge_page_ack = 1'b0;
      repeat (3) @(posedge trn_clk);
      @(negedge trn_clk);
      outs_a("rst_a", 1'b0, 1'b0, 1'b0, 5'd0);
      check("rst_a_page", 32'(dut_a.page_qwords), 32'd0);
      outs_b("rst_b", 1'b0, 1'b0, 1'b0, 5'd0);
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step_a(vecs[i].wr, vecs[i].rd, vecs[i].hpa, vecs[i].tack, vecs[i].cack);
         outs_a($sformatf("v%0d", i), vecs[i].trig, vecs[i].last, vecs[i].chg, vecs[i].qw);
         check($sformatf("v%0d_page", i), 32'(dut_a.page_qwords), 32'(vecs[i].page));
      end

      // Timeout: 5 qwords pending, short TLP forced on the 1024th idle cycle
      step_a(29, 24, 1'b1, 1'b0, 1'b0);
      early = if_a.send_last_tlp | if_a.trigger_tlp;
      for (int i = 2; i <= 1023; i++) begin
         step_a(29, 24, 1'b1, 1'b0, 1'b0);
         early = early | if_a.send_last_tlp | if_a.trigger_tlp;
      end
      check("to_early", 32'(early), 32'd0);
      step_a(29, 24, 1'b1, 1'b0, 1'b0);
      outs_a("to_fire", 1'b0, 1'b1, 1'b0, 5'd5);
      step_a(29, 24, 1'b0, 1'b0, 1'b0);
      outs_a("to_hold_nopage", 1'b0, 1'b1, 1'b0, 5'd5);
      step_a(29, 29, 1'b1, 1'b0, 1'b0);
      outs_a("to_chg", 1'b0, 1'b0, 1'b1, 5'd5);
      check("to_chg_page", 32'(dut_a.page_qwords), 32'd1053);
      step_a(29, 29, 1'b1, 1'b0, 1'b0);
      outs_a("to_chg_hold", 1'b0, 1'b0, 1'b1, 5'd5);
      step_a(29, 29, 1'b1, 1'b0, 1'b1);
      outs_a("to_chg_ack", 1'b0, 1'b0, 1'b0, 5'd5);
      check("to_page_clr", 32'(dut_a.page_qwords), 32'd0);

      // Page boundary on a 40-qword page
      step_b(64, 0, 1'b0, 1'b0, 1'b0);
      outs_b("pb_nopage", 1'b0, 1'b0, 1'b0, 5'd0);
      step_b(64, 0, 1'b1, 1'b0, 1'b0);
      outs_b("pb_t1", 1'b1, 1'b0, 1'b0, 5'd16);
      step_b(64, 0, 1'b1, 1'b1, 1'b0);
      step_b(64, 16, 1'b1, 1'b0, 1'b0);
      check("pb_page16", 32'(dut_b.page_qwords), 32'd16);
      step_b(64, 16, 1'b1, 1'b0, 1'b0);
      outs_b("pb_t2", 1'b1, 1'b0, 1'b0, 5'd16);
      step_b(64, 16, 1'b1, 1'b1, 1'b0);
      step_b(64, 32, 1'b1, 1'b0, 1'b0);
      outs_b("pb_commit2", 1'b0, 1'b0, 1'b0, 5'd16);
      step_b(64, 32, 1'b1, 1'b0, 1'b0);
      outs_b("pb_last", 1'b0, 1'b1, 1'b0, 5'd8);
      step_b(64, 32, 1'b1, 1'b0, 1'b0);
      outs_b("pb_last_hold", 1'b0, 1'b1, 1'b0, 5'd8);
      step_b(64, 40, 1'b1, 1'b0, 1'b0);
      outs_b("pb_chg", 1'b0, 1'b0, 1'b1, 5'd8);
      check("pb_page40", 32'(dut_b.page_qwords), 32'd40);
      step_b(64, 40, 1'b1, 1'b0, 1'b1);
      outs_b("pb_chg_ack", 1'b0, 1'b0, 1'b0, 5'd8);
      check("pb_page0", 32'(dut_b.page_qwords), 32'd0);
      step_b(64, 40, 1'b1, 1'b0, 1'b0);
      outs_b("pb_next_page", 1'b1, 1'b0, 1'b0, 5'd16);
      step_b(64, 40, 1'b1, 1'b1, 1'b0);
      step_b(88, 56, 1'b1, 1'b0, 1'b0);
      step_b(88, 56, 1'b1, 1'b0, 1'b0);
      outs_b("pb_t4", 1'b1, 1'b0, 1'b0, 5'd16);
      step_b(88, 56, 1'b1, 1'b1, 1'b0);
      step_b(88, 72, 1'b1, 1'b0, 1'b0);
      step_b(88, 72, 1'b1, 1'b0, 1'b0);
      outs_b("rs_wait_last", 1'b0, 1'b1, 1'b0, 5'd8);

      // Asynchronous reset while in WAIT_LAST
      #2 rst_b_n = 1'b0;
      #1;
      outs_b("rs_async", 1'b0, 1'b0, 1'b0, 5'd0);
      check("rs_page", 32'(dut_b.page_qwords), 32'd0);
      repeat (2) @(posedge trn_clk);
      @(negedge trn_clk);
      rst_b_n = 1'b1;
      #1;
      outs_b("rs_release", 1'b0, 1'b0, 1'b0, 5'd0);
      check("rs_state", 32'(dut_b.state_q), 32'(IDLE));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
